// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op codes and buffer depth shared by the logic unit files
package logic_unit_pkg;

    localparam int OP_W      = 3;
    localparam int BUF_DEPTH = 2;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b100;
    localparam logic [OP_W-1:0] OP_RAND = 3'b101;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise op decode and zero flag
// LOGIC_UNIT_REDUCE_EN adds OR/AND reduction of a on ops 100/101; otherwise op[2] is ignored.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

`ifdef LOGIC_UNIT_REDUCE_EN
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_ROR:  y = {{(WIDTH-1){1'b0}}, |a};
            OP_RAND: y = {{(WIDTH-1){1'b0}}, &a};
            default: y = a | b;
        endcase
    end
`else
    logic unused_op_hi;
    assign unused_op_hi = op[OP_W-1];

    always_comb begin
        y = '0;
        case (op[1:0])
            OP_AND[1:0]: y = a & b;
            OP_OR[1:0]:  y = a | b;
            OP_NOR[1:0]: y = ~(a | b);
            default:     y = a ^ b;
        endcase
    end
`endif

    assign zero = (y == '0);

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - bitwise logic unit with a 2-entry skid buffer on the result
// Op decode lives in logic_unit_core (optional LOGIC_UNIT_REDUCE_EN reduction ops).
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero
);

    localparam logic [1:0] FULL = BUF_DEPTH[1:0];

    logic [WIDTH-1:0] core_y;
    logic             core_zero;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a    (in_a),
        .b    (in_b),
        .op   (in_op),
        .y    (core_y),
        .zero (core_zero)
    );

    logic [1:0]       count;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] slot0_y;
    logic [WIDTH-1:0] slot1_y;
    logic             slot0_zero;
    logic             slot1_zero;
    logic             accept;
    logic             emit;

    assign out_valid = (count != 2'd0);
    assign out_y     = slot0_y;
    assign out_zero  = slot0_zero;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_comb begin
        count_next = count;
        case ({accept, emit})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // in_ready is registered from count_next so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 2'd0;
            in_ready   <= 1'b0;
            slot0_y    <= '0;
            slot1_y    <= '0;
            slot0_zero <= 1'b0;
            slot1_zero <= 1'b0;
        end else begin
            count    <= count_next;
            in_ready <= (count_next < FULL);
            if (emit && (count == FULL)) begin
                slot0_y    <= slot1_y;
                slot0_zero <= slot1_zero;
            end
            // accept with emit only happens at count 1, where the new beat becomes head
            if (accept) begin
                if ((count == 2'd0) || emit) begin
                    slot0_y    <= core_y;
                    slot0_zero <= core_zero;
                end else begin
                    slot1_y    <= core_y;
                    slot1_zero <= core_zero;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - randomized bench for logic_unit_pipe against a queue model
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;

    int total = 0;
    int bad   = 0;

    logic [8:0] q[$];
    logic       m_rdy   = 1'b0;
    logic       m_clear = 1'b1;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_zero  (out_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int sel;
`ifdef LOGIC_UNIT_REDUCE_EN
        if (op == 3'd4) return (a != 8'd0) ? 8'd1 : 8'd0;
        if (op == 3'd5) return (a == 8'hFF) ? 8'd1 : 8'd0;
        if (op >= 3'd6) return a | b;
`endif
        sel = int'(op) % 4;
        if (sel == 0) return a & b;
        if (sel == 1) return a | b;
        if (sel == 2) return 8'hFF - (a | b);
        return a ^ b;
    endfunction

    // Checks visible state at the negedge, drives the next inputs, then advances the model.
    task automatic cycle(input logic r, input logic iv, input logic ordy,
                         input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         output logic acc);
        logic       em;
        logic [7:0] y;
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
        if (q.size() != 0) begin
            chk("out_y", {24'd0, out_y}, {24'd0, q[0][7:0]});
            chk("out_zero", {31'd0, out_zero}, {31'd0, q[0][8]});
        end else if (m_clear) begin
            chk("out_y_clr", {24'd0, out_y}, 32'd0);
            chk("out_zero_clr", {31'd0, out_zero}, 32'd0);
        end
        rst = r; in_valid = iv; out_ready = ordy; in_a = a; in_b = b; in_op = op;
        acc = 1'b0;
        if (r) begin
            q.delete();
            m_rdy   = 1'b0;
            m_clear = 1'b1;
        end else begin
            acc = iv && m_rdy;
            em  = (q.size() != 0) && ordy;
            if (em) void'(q.pop_front());
            if (acc) begin
                y = ref_y(a, b, op);
                q.push_back({y == 8'd0, y});
                m_clear = 1'b0;
            end
            m_rdy = (q.size() < 2);
        end
    endtask

    initial begin
        logic       acc;
        logic [7:0] ha;
        logic [7:0] hb;
        int         tries;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 8'h5A; in_b = 8'hA5; in_op = 3'd1;
        @(posedge clk);

        // reset with a beat offered throughout
        cycle(1, 1, 1, 8'h5A, 8'hA5, 3'd1, acc);
        cycle(1, 1, 1, 8'h5A, 8'hA5, 3'd1, acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);

        // four ops, full throughput
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 8'hF0, 8'h0F, 3'(i), acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);

        // back-pressure: third beat held until space frees
        cycle(0, 1, 0, 8'h11, 8'h22, 3'd3, acc);
        cycle(0, 1, 0, 8'h33, 8'h0C, 3'd1, acc);
        cycle(0, 1, 0, 8'h55, 8'h55, 3'd3, acc);
        cycle(0, 1, 0, 8'h55, 8'h55, 3'd3, acc);
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 10) begin
            cycle(0, 1, 1, 8'h55, 8'h55, 3'd3, acc);
            tries++;
        end
        chk("held_beat_accepted", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);

        // steady count of one with push and pop every cycle
        cycle(0, 1, 0, 8'h01, 8'h02, 3'd1, acc);
        for (int i = 0; i < 20; i++)
            cycle(0, 1, 1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 3)), acc);
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);

        // reduction opcode
        cycle(0, 1, 1, 8'h00, 8'h3C, 3'd4, acc);
        cycle(0, 1, 1, 8'h10, 8'h3C, 3'd4, acc);
        cycle(0, 1, 1, 8'h10, 8'h10, 3'd4, acc);
        cycle(0, 1, 1, 8'hFF, 8'h81, 3'd5, acc);
        cycle(0, 1, 1, 8'h0A, 8'h50, 3'd6, acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);

        // reset with two beats buffered, then a normal beat
        cycle(0, 1, 0, 8'hC3, 8'h3C, 3'd1, acc);
        cycle(0, 1, 0, 8'hC3, 8'h0F, 3'd0, acc);
        cycle(1, 0, 1, 8'h00, 8'h00, 3'd0, acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);
        cycle(0, 1, 1, 8'h96, 8'h69, 3'd3, acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);
        cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            ha = 8'($urandom);
            hb = ($urandom_range(0, 3) == 0) ? ~ha : 8'($urandom);
            cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0), ha, hb, 3'($urandom), acc);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00, 8'h00, 3'd0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
